// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor (optional add mode:
// SERIAL_SUBTRACTOR_ADD_MODE_EN).
package serial_sub_pkg;

  localparam int SS_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Subtract flags overflow when operand signs differ, add when they match;
  // in both cases the result sign must have left a's sign.
  function automatic logic ovf_rule(input logic a_msb, input logic b_msb,
                                    input logic r_msb, input logic add);
    return (a_msb ^ b_msb ^ add) & (r_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
// The add port exists only with SERIAL_SUBTRACTOR_ADD_MODE_EN.
interface serial_subtractor_if #(
  parameter int WIDTH = serial_sub_pkg::SS_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic             add;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             ovf;

  modport master (
    output start, a, b, b_in,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    output add,
`endif
    input  busy, done, diff, b_out, ovf
  );

  modport slave (
    input  start, a, b, b_in,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    input  add,
`endif
    output busy, done, diff, b_out, ovf
  );
endinterface

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full subtractor; with SERIAL_SUBTRACTOR_ADD_MODE_EN it doubles as a
// full adder when i_add is set.
module fs_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bor,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  input  logic i_add,
`endif
  output logic o_d,
  output logic o_bor
);
  logic w_a;

  // Inverting a turns the borrow equation into the carry equation.
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  assign w_a = i_a ^ i_add;
`else
  assign w_a = i_a;
`endif

  assign o_d   = i_a ^ i_b ^ i_bor;
  assign o_bor = (~w_a & i_b) | (~(w_a ^ i_b) & i_bor);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - b_in, LSB first, one bit per clock behind start/done.
// SERIAL_SUBTRACTOR_ADD_MODE_EN adds an add/subtract select.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter  int WIDTH = SS_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bor, r_a_msb, r_b_msb;
  logic             r_busy, r_done, r_bout, r_ovf;
  logic             w_d, w_bor, w_add;
  logic [WIDTH-1:0] w_res_nxt;

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic r_add;
  assign w_add = r_add;
`else
  assign w_add = 1'b0;
`endif

  fs_cell u_cell (
    .i_a   (r_a[0]),
    .i_b   (r_b[0]),
    .i_bor (r_bor),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    .i_add (r_add),
`endif
    .o_d   (w_d),
    .o_bor (w_bor)
  );

  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_diff  <= '0;
      r_cnt   <= '0;
      r_bor   <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      r_add   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_bor   <= bus.b_in;
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
            r_add   <= bus.add;
`endif
          end
        end
        SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_bor <= w_bor;
          r_res <= w_res_nxt;
          r_cnt <= r_cnt + 1'b1;
          // Published outputs only move here, so they hold through the next op.
          if (r_cnt == LAST) begin
            r_diff  <= w_res_nxt;
            r_bout  <= w_bor;
            r_ovf   <= ovf_rule(r_a_msb, r_b_msb, w_d, w_add);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.diff  = r_diff;
  assign bus.b_out = r_bout;
  assign bus.ovf   = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: arithmetic reference model, driver
// pushes expectations on accepted starts, monitor checks every cycle.
module tb_serial_subtractor;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           done_edge;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   busy_until = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  exp_t last = '{diff: '0, bout: 1'b0, ovf: 1'b0, done_edge: 0};

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int bin, input bit add);
    exp_t m;
    int r, sa, sb, sr;
    sa = (a >= 2**(W-1)) ? a - 2**W : a;
    sb = (b >= 2**(W-1)) ? b - 2**W : b;
    if (add) begin
      r = a + b + bin;  sr = sa + sb + bin;  m.bout = (r >= 2**W);
    end else begin
      r = a - b - bin;  sr = sa - sb - bin;  m.bout = (r < 0);
    end
    m.diff = W'(r);
    m.ovf  = (sr < -(2**(W-1))) || (sr > 2**(W-1) - 1);
    m.done_edge = 0;
    return m;
  endfunction

  // Called at a negedge; a start is accepted only if the block is idle by the next edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, input bit add);
    int e;
    exp_t m;
    e = cyc + 1;
    if (e > busy_until) begin
      m = model(int'(a), int'(b), int'(bin), add);
      m.done_edge = e + W;
      q.push_back(m);
      busy_until = e + W;
    end
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.b_in = bin;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    bus.add = add;
`endif
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.b_in = 1'($urandom);
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    bus.add = 1'($urandom);
`endif
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cyc < busy_until && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (cyc < busy_until) begin
      tests++;
      fails++;
      $display("FAIL wait_idle timeout cyc=%0d expected_done=%0d", cyc, busy_until);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    busy_until = 0;
    last = '{diff: '0, bout: 1'b0, ovf: 1'b0, done_edge: 0};
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_diff", 32'(bus.diff), 0);
    chk("rst_bout", 32'(bus.b_out), 0);
    chk("rst_ovf",  32'(bus.ovf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: done and busy timing, then published outputs against the last expected result.
  always @(posedge clk) begin
    bit exp_done;
    #1;
    exp_done = (q.size() > 0) && (q[0].done_edge == cyc);
    chk("done", 32'(bus.done), 32'(exp_done));
    chk("busy", 32'(bus.busy), 32'(cyc < busy_until));
    if (exp_done) last = q.pop_front();
    chk("diff", 32'(bus.diff), 32'(last.diff));
    chk("b_out", 32'(bus.b_out), 32'(last.bout));
    chk("ovf", 32'(bus.ovf), 32'(last.ovf));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.b_in = 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    bus.add = 1'b0;
`endif
    @(negedge clk);
    do_reset();

    issue(4'h7, 4'h3, 1'b0, 1'b0); wait_idle();
    issue(4'h3, 4'h7, 1'b0, 1'b0); wait_idle();
    issue(4'h8, 4'h1, 1'b0, 1'b0); wait_idle();
    issue(4'h5, 4'h2, 1'b1, 1'b0); wait_idle();
    issue(4'h0, 4'h1, 1'b0, 1'b0); wait_idle();

    // start while busy is ignored, then a start on the done cycle is accepted
    issue(4'h7, 4'h3, 1'b0, 1'b0);
    @(negedge clk);
    issue(4'h9, 4'h9, 1'b0, 1'b0);
    wait_idle();
    issue(4'h5, 4'h2, 1'b0, 1'b0);
    wait_idle();

    // reset mid-operation discards the result
    issue(4'h6, 4'h1, 1'b0, 1'b0);
    @(negedge clk);
    do_reset();
    issue(4'h6, 4'h1, 1'b0, 1'b0); wait_idle();

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    issue(4'h7, 4'h2, 1'b0, 1'b1); wait_idle();
    issue(4'hF, 4'h1, 1'b0, 1'b1); wait_idle();
`endif

    for (int i = 0; i < 200; i++) begin
      bit add = 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      add = 1'($urandom);
`endif
      case ($urandom_range(0, 3))
        0:       repeat ($urandom_range(1, 3)) @(negedge clk);
        1:       ;
        default: wait_idle();
      endcase
      issue(W'($urandom), W'($urandom), 1'($urandom), add);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("drain", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
